lfsr_stream_gen: RTL and testbench



---
 rtl/lfsr_pkg.sv | 86 ++++++++
 rtl/lfsr_step.sv | 34 +++
 rtl/lfsr_stream_gen.sv | 117 +++++++++++
 tb/tb_lfsr_stream_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
//------------------------------------------------------------------------------
// Module      : lfsr_pkg
// Description : Shared types and helpers for the LFSR stream generator:
//               maximal-length tap table and a generic single-shift function.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lfsr_pkg;

    localparam int c_MAX_WIDTH = 32;

    // Result of one Fibonacci shift: next register value and the bit shifted out
    typedef struct packed {
        logic [c_MAX_WIDTH-1:0] state;
        logic                   out;
    } lfsr_res_t;

    // Maximal-length feedback masks; bit i set means stage i+1 feeds back
    function automatic logic [c_MAX_WIDTH-1:0] default_taps(input int width);
        logic [c_MAX_WIDTH-1:0] t;
        case (width)
            3:       t = 32'h0000_0006;
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0829;
            13:      t = 32'h0000_100D;
            14:      t = 32'h0000_2015;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_D008;
            17:      t = 32'h0001_2000;
            18:      t = 32'h0002_0400;
            19:      t = 32'h0004_0023;
            20:      t = 32'h0009_0000;
            21:      t = 32'h0014_0000;
            22:      t = 32'h0030_0000;
            23:      t = 32'h0042_0000;
            24:      t = 32'h00E1_0000;
            25:      t = 32'h0120_0000;
            26:      t = 32'h0200_0023;
            27:      t = 32'h0400_0013;
            28:      t = 32'h0900_0000;
            29:      t = 32'h1400_0000;
            30:      t = 32'h2000_0029;
            31:      t = 32'h4800_0000;
            32:      t = 32'h8020_0003;
            default: t = 32'h0000_0000;
        endcase
        return t;
    endfunction

    // One Fibonacci shift of a width-bit register held in the low bits of s:
    // feedback enters at bit 0, the bit leaving is s[width-1]
    function automatic lfsr_res_t lfsr_next(input logic [c_MAX_WIDTH-1:0] s,
                                            input logic [c_MAX_WIDTH-1:0] taps,
                                            input int                     width);
        lfsr_res_t r;
        logic      fb;
        fb = 1'b0;
        r  = '0;
        for (int i = 0; i < c_MAX_WIDTH; i++) begin
            if (i < width) begin
                fb = fb ^ (s[i] & taps[i]);
            end
            if (i == width - 1) begin
                r.out = s[i];
            end
        end
        for (int i = 1; i < c_MAX_WIDTH; i++) begin
            if (i < width) begin
                r.state[i] = s[i-1];
            end
        end
        r.state[0] = fb;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_step.sv
//------------------------------------------------------------------------------
// Module      : lfsr_step
// Description : Combinational single Fibonacci shift stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] state_o,
    output logic             out_o
);

    lfsr_res_t w_res;
    logic      w_unused_hi;

    // Evaluate one shift on the zero-extended register
    always_comb begin
        w_res = lfsr_next(c_MAX_WIDTH'(state_i), c_MAX_WIDTH'(TAPS), WIDTH);
    end

    assign state_o     = w_res.state[WIDTH-1:0];
    assign out_o       = w_res.out;
    // Upper bits of the generic result are always zero for narrow registers
    assign w_unused_hi = ^w_res.state;

endmodule

`default_nettype wire

// File: rtl/lfsr_stream_gen.sv
//------------------------------------------------------------------------------
// Module      : lfsr_stream_gen
// Description : Parametrised Fibonacci LFSR PRBS generator with multi-step
//               advance, seed load with zero-seed protection, enabled-cycle
//               counter and period-completion pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lfsr_stream_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(default_taps(WIDTH)),
    parameter int               STEPS        = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] state_o,
    output logic [STEPS-1:0] dout_o,
    output logic             sout_o,
    output logic [WIDTH-1:0] cnt_o,
    output logic             period_done_o,
    output logic             seed_err_o
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_q,   ref_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [STEPS-1:0] dout_q,  dout_d;
    logic             pd_q,    pd_d;
    logic             serr_q,  serr_d;

    logic [WIDTH-1:0] w_chain [STEPS+1];
    logic [STEPS-1:0] w_out;
    logic [WIDTH-1:0] w_adv;

    assign w_chain[0] = state_q;

    for (genvar k = 0; k < STEPS; k++) begin : g_step
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_step (
            .state_i (w_chain[k]),
            .state_o (w_chain[k+1]),
            .out_o   (w_out[k])
        );
    end

    // An all-zero register would lock up; restart from the default seed instead
    assign w_adv = (state_q == '0) ? DEFAULT_SEED : w_chain[STEPS];

    // Next-state selection: load beats advance, idle holds everything but the pulse
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        pd_d    = 1'b0;
        serr_d  = serr_q;
        if (load_i) begin
            if (seed_i != '0) begin
                state_d = seed_i;
                ref_d   = seed_i;
                serr_d  = 1'b0;
            end else begin
                state_d = DEFAULT_SEED;
                ref_d   = DEFAULT_SEED;
                serr_d  = 1'b1;
            end
            cnt_d  = '0;
            dout_d = '0;
        end else if (en_i) begin
            state_d = w_adv;
            cnt_d   = cnt_q + WIDTH'(1);
            dout_d  = w_out;
            pd_d    = (w_adv == ref_q);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= DEFAULT_SEED;
            ref_q   <= DEFAULT_SEED;
            cnt_q   <= '0;
            dout_q  <= '0;
            pd_q    <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            pd_q    <= pd_d;
            serr_q  <= serr_d;
        end
    end

    assign state_o       = state_q;
    assign dout_o        = dout_q;
    assign sout_o        = state_q[WIDTH-1];
    assign cnt_o         = cnt_q;
    assign period_done_o = pd_q;
    assign seed_err_o    = serr_q;

    // The register must never hold zero once out of reset
    a_no_lockup: assert property (@(posedge clk_i) disable iff (!reset_ni) state_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_lfsr_stream_gen.sv
//------------------------------------------------------------------------------
// Module      : tb_lfsr_stream_gen
// Description : Scoreboard bench for lfsr_stream_gen (STEPS=1 and STEPS=2).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lfsr_stream_gen;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       load;
    logic [7:0] seed;

    logic [7:0] st1, cnt1, st2, cnt2;
    logic [0:0] dout1;
    logic [1:0] dout2;
    logic       sout1, pd1, serr1, sout2, pd2, serr2;

    lfsr_stream_gen #(.WIDTH(8), .STEPS(1)) u_dut1 (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .en_i          (en),
        .load_i        (load),
        .seed_i        (seed),
        .state_o       (st1),
        .dout_o        (dout1),
        .sout_o        (sout1),
        .cnt_o         (cnt1),
        .period_done_o (pd1),
        .seed_err_o    (serr1)
    );

    lfsr_stream_gen #(.WIDTH(8), .STEPS(2)) u_dut2 (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .en_i          (en),
        .load_i        (load),
        .seed_i        (seed),
        .state_o       (st2),
        .dout_o        (dout2),
        .sout_o        (sout2),
        .cnt_o         (cnt2),
        .period_done_o (pd2),
        .seed_err_o    (serr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] st1;
        logic       dout1;
        logic [7:0] st2;
        logic [1:0] dout2;
        logic [7:0] cnt;
        logic       pd1;
        logic       pd2;
        logic       serr;
        bit         hchk;
        logic [7:0] hst1;
        logic [7:0] hcnt;
        logic       hpd1;
        logic       hserr;
        bit         h2chk;
        logic [7:0] hst2;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int mon_cyc  = 0;

    // Reference model state
    logic [7:0] m1, m2, mref, mcnt;
    logic       md1, mpd1, mpd2, mserr;
    logic [1:0] md2;

    // Hand-computed expectations attached to the next driven cycle
    bit         h_chk  = 0;
    logic [7:0] h_st1  = '0;
    logic [7:0] h_cnt  = '0;
    logic       h_pd1  = 1'b0;
    logic       h_serr = 1'b0;
    bit         h2_chk = 0;
    logic [7:0] h_st2  = '0;

    logic [7:0] seq5 [5] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

    // x^8+x^6+x^5+x^4+1 written out directly: returns {out bit, next state}
    function automatic logic [8:0] mshift(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[7], s[6:0], fb};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at monitor cycle %0d: got %0h, expected %0h", nm, mon_cyc, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic l, input logic [7:0] sd);
        logic [8:0] t;
        exp_t       rec;
        reset_n = r;
        en      = e;
        load    = l;
        seed    = sd;
        if (!r) begin
            m1 = 8'h01; m2 = 8'h01; mref = 8'h01; mcnt = 8'h00;
            md1 = 1'b0; md2 = 2'b00; mpd1 = 1'b0; mpd2 = 1'b0; mserr = 1'b0;
        end else if (l) begin
            if (sd != 8'h00) begin
                m1 = sd; m2 = sd; mref = sd; mserr = 1'b0;
            end else begin
                m1 = 8'h01; m2 = 8'h01; mref = 8'h01; mserr = 1'b1;
            end
            mcnt = 8'h00; md1 = 1'b0; md2 = 2'b00; mpd1 = 1'b0; mpd2 = 1'b0;
        end else if (e) begin
            t = mshift(m1); md1 = t[8]; m1 = t[7:0];
            t = mshift(m2); md2[0] = t[8]; m2 = t[7:0];
            t = mshift(m2); md2[1] = t[8]; m2 = t[7:0];
            mcnt = mcnt + 8'd1;
            mpd1 = (m1 == mref);
            mpd2 = (m2 == mref);
        end else begin
            mpd1 = 1'b0;
            mpd2 = 1'b0;
        end
        rec.st1 = m1;   rec.dout1 = md1; rec.st2 = m2; rec.dout2 = md2;
        rec.cnt = mcnt; rec.pd1 = mpd1;  rec.pd2 = mpd2; rec.serr = mserr;
        rec.hchk = h_chk; rec.hst1 = h_st1; rec.hcnt = h_cnt; rec.hpd1 = h_pd1; rec.hserr = h_serr;
        rec.h2chk = h2_chk; rec.hst2 = h_st2;
        @(posedge clk);
        sb_q.push_back(rec);
        h_chk  = 0;
        h2_chk = 0;
        #1;
    endtask

    task automatic hand(input logic [7:0] s, input logic [7:0] c, input logic p, input logic se);
        h_chk  = 1;
        h_st1  = s;
        h_cnt  = c;
        h_pd1  = p;
        h_serr = se;
    endtask

    // Monitor: compare registered outputs mid-cycle against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            mon_cyc++;
            check("state1",  32'(st1),   32'(e.st1));
            check("dout1",   32'(dout1), 32'(e.dout1));
            check("sout1",   32'(sout1), 32'(e.st1[7]));
            check("cnt1",    32'(cnt1),  32'(e.cnt));
            check("pd1",     32'(pd1),   32'(e.pd1));
            check("serr1",   32'(serr1), 32'(e.serr));
            check("state2",  32'(st2),   32'(e.st2));
            check("dout2",   32'(dout2), 32'(e.dout2));
            check("sout2",   32'(sout2), 32'(e.st2[7]));
            check("cnt2",    32'(cnt2),  32'(e.cnt));
            check("pd2",     32'(pd2),   32'(e.pd2));
            check("serr2",   32'(serr2), 32'(e.serr));
            if (e.hchk) begin
                check("hand_state1", 32'(st1),   32'(e.hst1));
                check("hand_cnt1",   32'(cnt1),  32'(e.hcnt));
                check("hand_pd1",    32'(pd1),   32'(e.hpd1));
                check("hand_serr1",  32'(serr1), 32'(e.hserr));
            end
            if (e.h2chk) begin
                check("hand_state2", 32'(st2), 32'(e.hst2));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       tog_en [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] tog_st [4] = '{8'h02, 8'h02, 8'h02, 8'h04};
        logic [7:0] tog_ct [4] = '{8'd1, 8'd1, 8'd1, 8'd2};

        reset_n = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        seed    = 8'h00;

        // Reset for two clocks
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        hand(8'h01, 8'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // First five advances from the default seed
        for (int i = 0; i < 5; i++) begin
            hand(seq5[i], 8'(i + 1), 1'b0, 1'b0);
            if (i == 0) begin
                h2_chk = 1;
                h_st2  = 8'h04;
            end
            drive(1'b1, 1'b1, 1'b0, 8'h00);
        end

        // Reset mid-run with en high: reset wins
        hand(8'h01, 8'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00);

        // Enable toggling 1,0,0,1
        for (int i = 0; i < 4; i++) begin
            hand(tog_st[i], tog_ct[i], 1'b0, 1'b0);
            drive(1'b1, tog_en[i], 1'b0, 8'h00);
        end

        // Full period from the default seed
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 255; i++) begin
            if (i == 254) begin
                hand(8'h01, 8'hFF, 1'b1, 1'b0);
                h2_chk = 1;
                h_st2  = 8'h01;
            end
            drive(1'b1, 1'b1, 1'b0, 8'h00);
        end

        // Load A5 with en high, then a full period back to A5
        hand(8'hA5, 8'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < 255; i++) begin
            if (i == 254) hand(8'hA5, 8'hFF, 1'b1, 1'b0);
            drive(1'b1, 1'b1, 1'b0, 8'h00);
        end

        // Zero seed: substitute default seed, sticky error through advances
        hand(8'h01, 8'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) hand(8'h71, 8'd10, 1'b0, 1'b1);
            drive(1'b1, 1'b1, 1'b0, 8'h00);
        end

        // Non-zero load clears the error
        hand(8'h3C, 8'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'h3C);

        // Full period plus one: pulse at 255, counter wraps to 0 without a pulse
        for (int i = 0; i < 256; i++) begin
            if (i == 254) hand(8'h3C, 8'hFF, 1'b1, 1'b0);
            if (i == 255) hand(8'h79, 8'h00, 1'b0, 1'b0);
            drive(1'b1, 1'b1, 1'b0, 8'h00);
        end

        // Idle holds
        hand(8'h79, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);

        repeat (2) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
